approx_shift_add_mult_ctrl: RTL and testbench

//  Sequencer that time-shares one WIDTH-bit maskable carry adder to form an unsigned WIDTHxWIDTH product by shift-add.
//  The adder stays an external instance: this block drives its operands and mask and consumes its (WIDTH+1)-bit sum.

---
 rtl/approx_shift_add_mult_ctrl.sv | 112 +++++++++++
 tb/tb_approx_shift_add_mult_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/approx_shift_add_mult_ctrl.sv
// approx_shift_add_mult_ctrl
// Shift-add sequencer for an unsigned WIDTH x WIDTH multiply. It time-shares
// one external WIDTH-bit maskable carry adder. The adder's mask, latched per
// operation, selects exact or approximate stages.
module approx_shift_add_mult_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_mask,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic [WIDTH-1:0]   add_mask,
    output logic               add_en,
    input  logic [WIDTH:0]     add_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state_reg;
    logic [WIDTH-1:0]   h_reg;
    logic [WIDTH-1:0]   l_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   mask_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               in_calc;

    // The adder is only driven while stepping; the sum is consumed only when
    // the current multiplier bit (L[0]) is set.
    assign in_calc   = (state_reg == CALC);
    assign add_en    = in_calc && l_reg[0];
    assign add_a     = in_calc ? h_reg     : '0;
    assign add_b     = in_calc ? mcand_reg : '0;
    assign add_mask  = in_calc ? mask_reg  : '0;

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    // {H,L} is frozen in DONE, so the product stays stable under backpressure.
    assign product   = out_valid_reg ? {h_reg, l_reg} : '0;

    // Control FSM plus the H/L shift register, with registered handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            h_reg         <= '0;
            l_reg         <= '0;
            mcand_reg     <= '0;
            mask_reg      <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mcand_reg    <= in_a;
                        l_reg        <= in_b;
                        h_reg        <= '0;
                        mask_reg     <= in_mask;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (l_reg[0]) begin
                        h_reg <= add_sum[WIDTH:1];
                        l_reg <= {add_sum[0], l_reg[WIDTH-1:1]};
                    end else begin
                        h_reg <= {1'b0, h_reg[WIDTH-1:1]};
                        l_reg <= {h_reg[0], l_reg[WIDTH-1:1]};
                    end
                    if (cnt_reg == LAST_STEP) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises only after DONE exits: no same-edge turnaround.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_shift_add_mult_ctrl.sv
// Testbench for approx_shift_add_mult_ctrl: models the external maskable
// adder and checks every operation against an arithmetic reference.
module tb_approx_shift_add_mult_ctrl;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic [W-1:0]   in_mask = '0;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_mask;
    logic           add_en;
    logic [W:0]     add_sum;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    approx_shift_add_mult_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask),
        .add_a(add_a), .add_b(add_b), .add_mask(add_mask),
        .add_en(add_en), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product)
    );

    // Maskable adder: exact stages are full adders; approximate stages give
    // sum = a|b and carry-out = a&b, ignoring the incoming carry.
    function automatic logic [W:0] approx_add(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic [W-1:0] m);
        logic [W:0] r;
        logic c;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) begin
                r[i] = a[i] ^ b[i] ^ c;
                c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
            end else begin
                r[i] = a[i] | b[i];
                c    = a[i] & b[i];
            end
        end
        r[W] = c;
        return r;
    endfunction

    assign add_sum = approx_add(add_a, add_b, add_mask);

    // Reference: accumulate a into the high half for each set multiplier bit,
    // shifting the whole 2W-bit product right once per bit.
    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic [W-1:0] m);
        logic [2*W:0] acc;
        logic [W:0]   s;
        acc = {1'b0, {W{1'b0}}, b};
        for (int i = 0; i < W; i++) begin
            if (acc[0]) begin
                s   = approx_add(acc[2*W-1:W], a, m);
                acc = {s, acc[W-1:0]};
            end
            acc = acc >> 1;
        end
        return acc[2*W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One operation: accept, watch each CALC cycle, hold out_ready low for
    // 'hold' cycles with ignored in_valid pulses, then hand the result off.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] m, input int hold);
        logic [2*W-1:0] exp;
        int lat;
        int en_cnt;
        int exp_en;
        exp = ref_mult(a, b, m);
        exp_en = $countones(b);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_a = a; in_b = b; in_mask = m;
        tick();
        in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); in_mask = W'($urandom);
        lat = 0;
        en_cnt = 0;
        while (!out_valid && lat < 20) begin
            if (in_ready) check("calc_in_ready", 32'(in_ready), 32'd0);
            if (add_en) begin
                en_cnt++;
                check("add_mask", 32'(add_mask), 32'(m));
                check("add_b", 32'(add_b), 32'(a));
            end
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        check("add_en_cycles", 32'(en_cnt), 32'(exp_en));
        check("product", 32'(product), 32'(exp));
        if (m == 4'hF) check("product_exact", 32'(product), 32'(a) * 32'(b));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'(k % 2 == 0);
            in_a = W'($urandom); in_b = W'($urandom);
            tick();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_product", 32'(product), 32'(exp));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_add_en", 32'(add_en), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_product", 32'(product), 32'd0);
        $display("op a=%0d b=%0d mask=%b product=%0d expected=%0d lat=%0d add_en=%0d",
                 a, b, m, product, exp, lat, en_cnt);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_add_en", 32'(add_en), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst = 1'b0;
        tick();

        run_op(4'd13, 4'd11, 4'b1111, 0);
        run_op(4'd15, 4'd15, 4'b1111, 0);
        run_op(4'd9,  4'd0,  4'b1111, 0);
        run_op(4'd13, 4'd11, 4'b1111, 5);
        run_op(4'd7,  4'd6,  4'b0000, 0);

        // Asynchronous reset in the second CALC cycle.
        in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15; in_mask = 4'b1111;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_add_en", 32'(add_en), 32'd0);
        check("midrst_add_a", 32'(add_a), 32'd0);
        check("midrst_add_mask", 32'(add_mask), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        $display("mid-CALC reset in_ready=%0d out_valid=%0d add_en=%0d", in_ready, out_valid, add_en);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op(4'd3, 4'd5, 4'b1111, 0);

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] ra, rb, rm;
            ra = W'($urandom);
            rb = W'($urandom);
            rm = (n % 3 == 0) ? 4'b1111 : W'($urandom);
            run_op(ra, rb, rm, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
